spi_flash_responder: RTL and testbench
======================================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter JEDEC_ID, default 24'hEF4016, the 3-byte ID returned for command 0x9F, MSB byte first.
REQ-002 Parameter STATUS_VAL, default 8'h00, the value returned for command 0x05.
REQ-003 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 clk_48mhz  in  1  system clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 spi_cs  in  1  chip select from the SPI initiator, active-low, asynchronous to clk_48mhz.
REQ-007 spi_sck  in  1  SPI clock, mode 0, asynchronous, at most clk_48mhz/4.
REQ-008 spi_mosi  in  1  serial data from the initiator, MSB first.
REQ-009 spi_miso  out  1  serial data to the initiator, MSB first.
REQ-010 spi_miso_oe  out  1  MISO output enable; 1 only while a response byte is being shifted.
REQ-011 mem_addr  out  24  byte address of the backing-store read port.
REQ-012 mem_rd_en  out  1  one-cycle read strobe; mem_rd_data is valid exactly 1 cycle later.
REQ-013 mem_rd_data  in  8  backing-store read data.
REQ-014 cmd_valid  out  1  one-cycle pulse when a command byte is complete.
REQ-015 cmd_byte  out  8  last received command byte; it is held until the next cmd_valid.

Function
REQ-016 spi_cs, spi_sck and spi_mosi SHALL each pass through a 2-flop synchronizer.
- SCK edges are detected from the synchronized SCK.
- Fixed latency from a pin transition to an internal edge event: 3 cycles.
REQ-017 On each SCK rising event with CS low, the block SHALL sample MOSI into an 8-bit shift register.
REQ-018 On each SCK falling event with CS low, the block SHALL advance the MISO shift register.
REQ-019 A bit counter (0..7) SHALL wrap at 8 to mark byte completion, and SHALL clear whenever CS is high.
REQ-020 The FSM states SHALL be IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
- IDLE->CMD on the CS falling event.
- Any state->IDLE on the CS rising event, even mid-byte.
REQ-021 At the end of the command byte (CMD state), the block SHALL pulse cmd_valid and decode the command:
- 0x03 -> ADDR.
- 0x0B -> ADDR, then DUMMY for 8 bits.
- 0x9F, 0x05 -> DATA.
- 0xB9: set powered_down, then go to IGNORE.
- 0xAB: clear powered_down, then go to IGNORE.
- Any other value -> IGNORE.
REQ-022 While powered_down=1, every command except 0xAB SHALL go to IGNORE; cmd_valid still pulses.
REQ-023 In ADDR, the block SHALL shift 24 bits MSB first into mem_addr.
- On the 24th rising event it asserts mem_rd_en for 1 cycle.
- For 0x0B, the read is issued at the end of DUMMY instead.
REQ-024 mem_rd_data SHALL be loaded into the MISO shift register at the next SCK falling event.
- At that load, spi_miso = bit7 and spi_miso_oe = 1.
- No extra byte of latency: the first data bit follows the last address/dummy bit directly.
REQ-025 In DATA for a read command, the block SHALL prefetch each following byte:
- When a byte's bit 7 is sent, mem_addr increments and mem_rd_en pulses.
- mem_addr wraps from 24'hFFFFFF to 24'h000000.
REQ-026 In DATA for 0x9F, the block SHALL send JEDEC_ID[23:16], [15:8], [7:0], then 8'h00 repeated.
REQ-027 In DATA for 0x05, the block SHALL send STATUS_VAL repeated for as long as CS stays low.
REQ-028 In IGNORE and IDLE, spi_miso_oe SHALL be 0 and spi_miso 0.
REQ-029 When CS rises mid-byte, the block SHALL discard the partial byte and cancel any pending prefetch.
- No mem_rd_en is issued after the CS rising event.
REQ-030 When SCK falling and CS rising events occur in the same cycle, the CS event SHALL take priority.

Reset
REQ-031 During reset, the following SHALL be 0, the FSM SHALL be in IDLE, and powered_down SHALL be 0:
- spi_miso, spi_miso_oe, mem_rd_en, cmd_valid, cmd_byte, mem_addr.
- The bit counter and the synchronizers.
REQ-032 A reset asserted mid-transaction SHALL abort the transaction.
- After reset, the block waits for a fresh CS falling event; a CS already low is ignored until it goes high.

Verification
REQ-033 Read 0x03 at address 0x0000FE, 3 data bytes, memory[i]=i^8'hA5:
- mem_addr sequence 0x0000FE, 0x0000FF, 0x000100.
- MISO returns 0x5B, 0x5A, 0xA5.
REQ-034 Read 0x03 at 0xFFFFFF, 2 bytes -> mem_addr wraps to 0x000000; the second byte is memory[0].
REQ-035 Fast read 0x0B at 0x000010, dummy 0xFF, 1 byte -> exactly 8 dummy clocks, then memory[0x10]; mem_rd_en pulses once.
REQ-036 0x9F, 4 bytes read -> 0xEF, 0x40, 0x16, 0x00; cmd_valid pulses once with cmd_byte=0x9F.
REQ-037 Power-down sequence: 0xB9, then 0x9F -> MISO tristated (oe=0); then 0xAB, then 0x9F -> returns 0xEF.
REQ-038 0x03 with CS deasserted after 12 address bits, then a new 0x05 -> mem_rd_en never pulses for the aborted read; MISO returns 0x00 with oe=1.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI-mode-0 flash responder: read (0x03), fast read (0x0B), JEDEC ID (0x9F),
// status (0x05) and deep power-down (0xB9/0xAB), backed by a 1-cycle-latency read port.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_e;
  typedef enum logic [1:0] {M_READ, M_ID, M_STAT} mode_e;

  localparam logic [7:0] C_READ  = 8'h03;
  localparam logic [7:0] C_FAST  = 8'h0B;
  localparam logic [7:0] C_RDID  = 8'h9F;
  localparam logic [7:0] C_RDSR  = 8'h05;
  localparam logic [7:0] C_PDOWN = 8'hB9;
  localparam logic [7:0] C_PUP   = 8'hAB;

  logic [1:0]  cs_sync_q, sck_sync_q, mosi_sync_q;
  logic        cs_prev_q, sck_prev_q;
  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic        fast_q, fast_d, pd_q, pd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [1:0]  addr_cnt_q, addr_cnt_d, id_idx_q, id_idx_d;
  logic [23:0] addr_q, addr_d;
  logic        rd_en_q, rd_en_d, rd_vld_q;
  logic [7:0]  hold_q, hold_d, tx_q, tx_d;
  logic        oe_q, oe_d, cv_q, cv_d;
  logic [7:0]  cb_q, cb_d;

  logic       cs_s, mosi_s, cs_fall, cs_rise, sck_rise, sck_fall, byte_done;
  logic [7:0] rx_byte, load_val, id_byte;

  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sck_rise  = sck_sync_q[1] & ~sck_prev_q & ~cs_s;
  assign sck_fall  = ~sck_sync_q[1] & sck_prev_q & ~cs_s;
  assign byte_done = sck_rise && (cnt_q == 3'd7);
  assign rx_byte   = {rx_q, mosi_s};
  // Read data may land in the same cycle as the load edge, so bypass the holding reg.
  assign load_val  = rd_vld_q ? mem_rd_data : hold_q;

  always_comb begin
    case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    fast_d     = fast_q;
    pd_d       = pd_q;
    rx_d       = rx_q;
    addr_cnt_d = addr_cnt_q;
    id_idx_d   = id_idx_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    hold_d     = rd_vld_q ? mem_rd_data : hold_q;
    tx_d       = tx_q;
    oe_d       = oe_q;
    cv_d       = 1'b0;
    cb_d       = cb_q;

    if (cs_s)          cnt_d = 3'd0;
    else if (sck_rise) cnt_d = cnt_q + 3'd1;
    else               cnt_d = cnt_q;
    if (sck_rise) rx_d = rx_byte[6:0];

    case (state_q)
      IDLE: begin
        oe_d = 1'b0;
        if (cs_fall) state_d = CMD;
      end
      CMD: if (byte_done) begin
        cv_d       = 1'b1;
        cb_d       = rx_byte;
        addr_cnt_d = 2'd0;
        id_idx_d   = 2'd0;
        state_d    = IGNORE;
        if (!pd_q || rx_byte == C_PUP) begin
          case (rx_byte)
            C_READ:  begin state_d = ADDR; mode_d = M_READ; fast_d = 1'b0; end
            C_FAST:  begin state_d = ADDR; mode_d = M_READ; fast_d = 1'b1; end
            C_RDID:  begin state_d = DATA; mode_d = M_ID;   end
            C_RDSR:  begin state_d = DATA; mode_d = M_STAT; end
            C_PDOWN: pd_d = 1'b1;
            C_PUP:   pd_d = 1'b0;
            default: ;
          endcase
        end
      end
      ADDR: if (sck_rise) begin
        addr_d = {addr_q[22:0], mosi_s};
        if (byte_done) begin
          addr_cnt_d = addr_cnt_q + 2'd1;
          if (addr_cnt_q == 2'd2) begin
            if (fast_q) state_d = DUMMY;
            else begin state_d = DATA; rd_en_d = 1'b1; end
          end
        end
      end
      DUMMY: if (byte_done) begin
        state_d = DATA;
        rd_en_d = 1'b1;
      end
      DATA: if (sck_fall) begin
        // Counter back at 0 on a falling edge means a byte boundary: present a new MSB.
        if (cnt_q == 3'd0) begin
          oe_d = 1'b1;
          case (mode_q)
            M_READ: begin
              tx_d    = load_val;
              addr_d  = addr_q + 24'd1;
              rd_en_d = 1'b1;
            end
            M_ID: begin
              tx_d = id_byte;
              if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
            end
            default: tx_d = STATUS_VAL;
          endcase
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      default: oe_d = 1'b0;
    endcase

    if (cs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      rd_en_d = 1'b0;
      tx_d    = 8'h00;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
      state_q     <= IDLE;
      mode_q      <= M_READ;
      fast_q      <= 1'b0;
      pd_q        <= 1'b0;
      cnt_q       <= '0;
      rx_q        <= '0;
      addr_cnt_q  <= '0;
      id_idx_q    <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      hold_q      <= '0;
      tx_q        <= '0;
      oe_q        <= 1'b0;
      cv_q        <= 1'b0;
      cb_q        <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      cs_prev_q   <= cs_sync_q[1];
      sck_prev_q  <= sck_sync_q[1];
      state_q     <= state_d;
      mode_q      <= mode_d;
      fast_q      <= fast_d;
      pd_q        <= pd_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      addr_cnt_q  <= addr_cnt_d;
      id_idx_q    <= id_idx_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      rd_vld_q    <= rd_en_q;
      hold_q      <= hold_d;
      tx_q        <= tx_d;
      oe_q        <= oe_d;
      cv_q        <= cv_d;
      cb_q        <= cb_d;
    end
  end

  assign spi_miso    = oe_q & tx_q[7];
  assign spi_miso_oe = oe_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign cmd_valid   = cv_q;
  assign cmd_byte    = cb_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a mode-0 SPI initiator plus a memory
// whose byte at address i is i[7:0]^8'hA5.
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs, spi_sck, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [23:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data = 8'h00;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int cv_cnt = 0;
  logic [23:0] rd_q[$];

  spi_flash_responder dut (
    .clk_48mhz  (clk),
    .reset      (reset),
    .spi_cs     (spi_cs),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0] ^ 8'hA5;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      rd_q.push_back(mem_addr);
    end
    if (cmd_valid) cv_cnt <= cv_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx,
                      output logic oe_any, output logic oe_all);
    rx = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = tx[i];
      wait_clk(HALF);
      rx     = {rx[6:0], spi_miso};
      oe_any = oe_any | spi_miso_oe;
      oe_all = oe_all & spi_miso_oe;
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(3 * HALF);
  endtask

  initial begin
    logic [7:0] r;
    logic       oa, ol;
    int         qb, rb, cb;

    reset = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    wait_clk(5);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
    chk("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    reset = 1'b0;
    wait_clk(10);

    // Read 0x03 @ 0x0000FE, three bytes
    qb = rd_q.size();
    cs_low();
    xfer(8'h03, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    xfer(8'hFE, 8, r, oa, ol);
    chk("rd_addr_oe", {31'd0, oa}, 32'd0);
    xfer(8'h00, 8, r, oa, ol);
    chk("rd_b0", {24'd0, r}, 32'h5B);
    chk("rd_b0_oe", {31'd0, ol}, 32'd1);
    xfer(8'h00, 8, r, oa, ol);
    chk("rd_b1", {24'd0, r}, 32'h5A);
    xfer(8'h00, 8, r, oa, ol);
    chk("rd_b2", {24'd0, r}, 32'hA5);
    cs_high();
    chk("rd_cmd_byte", {24'd0, cmd_byte}, 32'h03);
    chk("rd_n_reads", {31'd0, rd_q.size() >= qb + 3}, 32'd1);
    if (rd_q.size() >= qb + 3) begin
      chk("rd_addr0", {8'd0, rd_q[qb]}, 32'h0000FE);
      chk("rd_addr1", {8'd0, rd_q[qb + 1]}, 32'h0000FF);
      chk("rd_addr2", {8'd0, rd_q[qb + 2]}, 32'h000100);
    end
    chk("idle_oe", {31'd0, spi_miso_oe}, 32'd0);

    // Read at 0xFFFFFF: address wraps to 0
    qb = rd_q.size();
    cs_low();
    xfer(8'h03, 8, r, oa, ol);
    xfer(8'hFF, 8, r, oa, ol);
    xfer(8'hFF, 8, r, oa, ol);
    xfer(8'hFF, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    chk("wrap_b0", {24'd0, r}, 32'h5A);
    xfer(8'h00, 8, r, oa, ol);
    chk("wrap_b1", {24'd0, r}, 32'hA5);
    cs_high();
    chk("wrap_n_reads", {31'd0, rd_q.size() >= qb + 2}, 32'd1);
    if (rd_q.size() >= qb + 2) chk("wrap_addr1", {8'd0, rd_q[qb + 1]}, 32'h000000);

    // Fast read 0x0B @ 0x10 with one dummy byte
    qb = rd_q.size();
    rb = rd_cnt;
    cs_low();
    xfer(8'h0B, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    xfer(8'h10, 8, r, oa, ol);
    chk("fast_no_rd_after_addr", rd_cnt - rb, 32'd0);
    xfer(8'hFF, 8, r, oa, ol);
    chk("fast_dummy_oe", {31'd0, oa}, 32'd0);
    chk("fast_one_rd", rd_cnt - rb, 32'd1);
    if (rd_q.size() > qb) chk("fast_addr", {8'd0, rd_q[qb]}, 32'h000010);
    xfer(8'h00, 8, r, oa, ol);
    chk("fast_b0", {24'd0, r}, 32'hB5);
    cs_high();

    // JEDEC ID
    cb = cv_cnt;
    cs_low();
    xfer(8'h9F, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    chk("id_b0", {24'd0, r}, 32'hEF);
    xfer(8'h00, 8, r, oa, ol);
    chk("id_b1", {24'd0, r}, 32'h40);
    xfer(8'h00, 8, r, oa, ol);
    chk("id_b2", {24'd0, r}, 32'h16);
    xfer(8'h00, 8, r, oa, ol);
    chk("id_b3", {24'd0, r}, 32'h00);
    cs_high();
    chk("id_cv_cnt", cv_cnt - cb, 32'd1);
    chk("id_cmd_byte", {24'd0, cmd_byte}, 32'h9F);

    // Power-down, ID ignored, power-up, ID works again
    cs_low(); xfer(8'hB9, 8, r, oa, ol); cs_high();
    cb = cv_cnt;
    cs_low();
    xfer(8'h9F, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    chk("pd_id_oe", {31'd0, oa}, 32'd0);
    chk("pd_id_data", {24'd0, r}, 32'h00);
    cs_high();
    chk("pd_cv_cnt", cv_cnt - cb, 32'd1);
    chk("pd_cmd_byte", {24'd0, cmd_byte}, 32'h9F);
    cs_low(); xfer(8'hAB, 8, r, oa, ol); cs_high();
    cs_low();
    xfer(8'h9F, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    chk("pu_id_b0", {24'd0, r}, 32'hEF);
    chk("pu_id_oe", {31'd0, ol}, 32'd1);
    cs_high();

    // Aborted read after 12 address bits, then status
    rb = rd_cnt;
    cs_low();
    xfer(8'h03, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    xfer(8'h00, 4, r, oa, ol);
    cs_high();
    cs_low();
    xfer(8'h05, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    chk("st_b0", {24'd0, r}, 32'h00);
    chk("st_b0_oe", {31'd0, ol}, 32'd1);
    xfer(8'h00, 8, r, oa, ol);
    chk("st_b1_oe", {31'd0, ol}, 32'd1);
    cs_high();
    chk("abort_no_rd", rd_cnt - rb, 32'd0);
    chk("st_cmd_byte", {24'd0, cmd_byte}, 32'h05);

    // Reset mid-transaction with CS held low: ignored until CS rises
    cs_low();
    xfer(8'h9F, 8, r, oa, ol);
    reset = 1'b1;
    wait_clk(4);
    chk("mid_rst_cmd_byte", {24'd0, cmd_byte}, 32'h00);
    reset = 1'b0;
    wait_clk(4);
    cb = cv_cnt;
    xfer(8'h9F, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    chk("mid_rst_oe", {31'd0, oa}, 32'd0);
    chk("mid_rst_cv", cv_cnt - cb, 32'd0);
    cs_high();
    cs_low();
    xfer(8'h9F, 8, r, oa, ol);
    xfer(8'h00, 8, r, oa, ol);
    chk("post_rst_id", {24'd0, r}, 32'hEF);
    cs_high();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
